// File: rtl/aud_time_counter.sv
// -----------------------------------------------------------------------------
// aud_time_counter
//
// Elapsed-playback-time counter for the audio recorder/player. Counts codec
// frames (rising edges of the asynchronous DAC LR clock) and scales them by the
// current play speed, so the seconds value reflects elapsed content time
// rather than wall time.
//
// Parameters:
//   SAMPLE_RATE  content samples per second; accumulator wraps at this value
//   MAX_SEC      saturation value of o_time (must be <= 63)
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_lrck     codec DACLRCK, asynchronous; one rising edge = one frame
//   i_start    one-cycle pulse: start (from IDLE) or resume (from PAUSE)
//   i_pause    one-cycle pulse: pause
//   i_stop     one-cycle pulse: stop and clear
//   i_speed    speed code, factor = i_speed + 1
//   i_is_slow  1 = divide frames by factor, 0 = multiply
//   o_time     elapsed seconds, 0..MAX_SEC
//   o_tick     one-cycle pulse on each o_time increment
//   o_running  high while in RUN
//   o_full     high while o_time == MAX_SEC
// -----------------------------------------------------------------------------
module aud_time_counter #(
   parameter int unsigned SAMPLE_RATE = 32000,
   parameter int unsigned MAX_SEC     = 63
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_lrck,
   input  logic       i_start,
   input  logic       i_pause,
   input  logic       i_stop,
   input  logic [2:0] i_speed,
   input  logic       i_is_slow,
   output logic [5:0] o_time,
   output logic       o_tick,
   output logic       o_running,
   output logic       o_full
);

   // acc < SAMPLE_RATE and inc <= 8, so acc + inc < SAMPLE_RATE + 8 always
   // fits ACC_W bits; no carry bit is needed for the sum.
   localparam int unsigned        ACC_W = $clog2(SAMPLE_RATE + 8);
   localparam logic [ACC_W-1:0]   SR_W  = ACC_W'(SAMPLE_RATE);
   localparam logic [5:0]         MAX_T = 6'(MAX_SEC);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic             lrck_s1;
   logic             lrck_s2;
   logic             lrck_prev;
   logic             frame;

   logic [ACC_W-1:0] acc_q;
   logic [2:0]       div_q;
   logic [5:0]       time_q;
   logic             tick_q;

   logic             full;
   logic             count_en;
   logic             fresh_start;
   logic [3:0]       inc;
   logic [2:0]       div_d;
   logic [ACC_W-1:0] acc_sum;
   logic             wrap;

   // ---------------------------------------------------------------------
   // LR clock synchronizer and rising-edge detector
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lrck_s1   <= 1'b0;
         lrck_s2   <= 1'b0;
         lrck_prev <= 1'b0;
      end else begin
         lrck_s1   <= i_lrck;
         lrck_s2   <= lrck_s1;
         lrck_prev <= lrck_s2;
      end
   end

   assign frame = lrck_s2 & ~lrck_prev;

   // ---------------------------------------------------------------------
   // Control FSM; priority stop > pause > start
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_stop) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               // a pause coinciding with start wins and is a no-op here
               if (!i_pause && i_start) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (i_pause) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
               if (!i_pause && i_start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Only a start out of IDLE clears the count; a resume from PAUSE keeps it.
   assign fresh_start = (state_q == ST_IDLE) && (state_d == ST_RUN);
   assign full        = (time_q == MAX_T);
   assign count_en    = frame && (state_q == ST_RUN) && !full;

   // ---------------------------------------------------------------------
   // Per-frame increment and accumulator arithmetic
   // ---------------------------------------------------------------------
   always_comb begin
      inc   = '0;
      div_d = div_q;
      if (i_is_slow) begin
         // >= rather than == so that lowering i_speed mid-count can never
         // leave the divider above the new terminal value
         if (div_q >= i_speed) begin
            inc   = 4'd1;
            div_d = '0;
         end else begin
            div_d = div_q + 3'd1;
         end
      end else begin
         inc = {1'b0, i_speed} + 4'd1;
      end
      acc_sum = acc_q + ACC_W'(inc);
      wrap    = (acc_sum >= SR_W);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_stop || fresh_start) begin
         acc_q  <= '0;
         div_q  <= '0;
         time_q <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (count_en) begin
            div_q <= div_d;
            if (wrap) begin
               acc_q  <= acc_sum - SR_W;
               time_q <= time_q + 6'd1;
               tick_q <= 1'b1;
            end else begin
               acc_q  <= acc_sum;
            end
         end
      end
   end

   assign o_time    = time_q;
   assign o_tick    = tick_q;
   assign o_running = (state_q == ST_RUN);
   assign o_full    = full;

endmodule

// File: tb/tb_aud_time_counter.sv
module tb_aud_time_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       lrck = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       stop = 1'b0;
   logic [2:0] speed = 3'd0;
   logic       slow = 1'b0;

   logic [5:0] time_m, time_s;
   logic       tick_m, tick_s, run_m, run_s, full_m, full_s;

   always #5 clk = ~clk;

   aud_time_counter #(.SAMPLE_RATE(8), .MAX_SEC(63)) dut (
      .i_clk(clk), .i_rst(rst), .i_lrck(lrck), .i_start(start),
      .i_pause(pause), .i_stop(stop), .i_speed(speed), .i_is_slow(slow),
      .o_time(time_m), .o_tick(tick_m), .o_running(run_m), .o_full(full_m)
   );

   aud_time_counter #(.SAMPLE_RATE(8), .MAX_SEC(3)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_lrck(lrck), .i_start(start),
      .i_pause(pause), .i_stop(stop), .i_speed(speed), .i_is_slow(slow),
      .o_time(time_s), .o_tick(tick_s), .o_running(run_s), .o_full(full_s)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int ticks_m = 0;
   int ticks_s = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard entries: expected o_time after a tick and the cycle it shows up.
   typedef struct {
      logic [5:0] t;
      int         c;
   } exp_t;
   exp_t sb[$];

   // Reference model of the main DUT (SAMPLE_RATE=8, MAX_SEC=63)
   int m_acc, m_div, m_time, m_state; // state: 0 idle, 1 run, 2 pause

   task automatic m_reset();
      m_acc = 0; m_div = 0; m_time = 0; m_state = 0;
      sb.delete();
   endtask

   task automatic m_frame();
      int inc;
      if (m_state == 1 && m_time != 63) begin
         if (slow) begin
            if (m_div >= int'(speed)) begin inc = 1; m_div = 0; end
            else begin inc = 0; m_div = m_div + 1; end
         end else begin
            inc = int'(speed) + 1;
         end
         m_acc = m_acc + inc;
         if (m_acc >= 8) begin
            m_acc  = m_acc - 8;
            m_time = m_time + 1;
            sb.push_back('{t: 6'(m_time), c: cyc + 3});
         end
      end
   endtask

   task automatic m_pulse(input logic s_start, input logic s_pause, input logic s_stop);
      if (s_stop) begin
         m_state = 0; m_acc = 0; m_div = 0; m_time = 0;
      end else if (s_pause) begin
         if (m_state == 1) m_state = 2;
      end else if (s_start) begin
         if (m_state == 0) begin
            m_state = 1; m_acc = 0; m_div = 0; m_time = 0;
         end else if (m_state == 2) begin
            m_state = 1;
         end
      end
   endtask

   // Monitor: every tick from the main DUT is popped and compared.
   always @(negedge clk) begin
      exp_t e;
      if (tick_s === 1'b1) ticks_s++;
      if (tick_m === 1'b1) begin
         ticks_m++;
         tests_run++;
         if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_tick: o_tick=1 o_time=%0d at cycle %0d, required no tick", time_m, cyc);
         end else begin
            e = sb.pop_front();
            if (time_m !== e.t || cyc != e.c) begin
               tests_failed++;
               $display("FAIL tick_sb: o_time=%0d at cycle %0d, required o_time=%0d at cycle %0d",
                        time_m, cyc, e.t, e.c);
            end
         end
      end
   end

   // --------------------------------------------------------------------
   // Stimulus helpers (all called from the negative clock edge)
   // --------------------------------------------------------------------
   task automatic pulse(input logic s_start, input logic s_pause, input logic s_stop);
      start = s_start; pause = s_pause; stop = s_stop;
      m_pulse(s_start, s_pause, s_stop);
      @(negedge clk);
      start = 1'b0; pause = 1'b0; stop = 1'b0;
   endtask

   task automatic send_frames(input int n);
      for (int i = 0; i < n; i++) begin
         lrck = 1'b1;
         m_frame();
         repeat (3) @(negedge clk);
         lrck = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; lrck = 1'b1; start = 1'b1;
      @(negedge clk);
      lrck = 1'b0; start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      repeat (4) @(negedge clk);
   endtask

   task automatic check_time_m(input string name, input int exp);
      // inline comparison kept per call site via name; single-purpose wrapper
      tests_run++;
      if (time_m !== 6'(exp)) begin
         tests_failed++;
         $display("FAIL %s: o_time=%0d, required %0d", name, time_m, exp);
      end
   endtask

   task automatic check_sb_empty(input string name);
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL %s: %0d expected ticks never seen, required 0", name, sb.size());
      end
   endtask

   // --------------------------------------------------------------------
   // Tests
   // --------------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      tests_run++;
      if ({time_m, tick_m, run_m, full_m} !== 9'd0) begin
         tests_failed++;
         $display("FAIL reset_main: time=%0d tick=%b run=%b full=%b, required all 0", time_m, tick_m, run_m, full_m);
      end
      tests_run++;
      if ({time_s, tick_s, run_s, full_s} !== 9'd0) begin
         tests_failed++;
         $display("FAIL reset_sat: time=%0d tick=%b run=%b full=%b, required all 0", time_s, tick_s, run_s, full_s);
      end
   endtask

   task automatic test_normal();
      int t0;
      speed = 3'd0; slow = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      tests_run++;
      if (run_m !== 1'b1) begin
         tests_failed++;
         $display("FAIL normal_running: o_running=%b, required 1", run_m);
      end
      t0 = ticks_m;
      send_frames(32);
      check_time_m("normal_time", 4);
      tests_run++;
      if (ticks_m - t0 != 4) begin
         tests_failed++;
         $display("FAIL normal_ticks: %0d ticks, required 4", ticks_m - t0);
      end
      check_sb_empty("normal_sb");
   endtask

   task automatic test_fast3();
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      speed = 3'd2; slow = 1'b0;
      send_frames(8);
      check_time_m("fast3_8frames", 3);
      send_frames(1);
      check_time_m("fast3_9frames", 3);
      // residual acc of 3 means exactly 5 more unit frames to the next second
      speed = 3'd0;
      send_frames(4);
      check_time_m("fast3_acc_residual_lo", 3);
      send_frames(1);
      check_time_m("fast3_acc_residual_hi", 4);
      check_sb_empty("fast3_sb");
   endtask

   task automatic test_slow();
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      speed = 3'd1; slow = 1'b1;
      send_frames(16);
      check_time_m("slow_half_16", 1);
      send_frames(1); // divider now 1
      check_time_m("slow_half_17", 1);
      speed = 3'd0;
      send_frames(7);
      check_time_m("slow_speed_drop_7", 1);
      send_frames(1);
      check_time_m("slow_speed_drop_8", 2);
      slow = 1'b0;
      check_sb_empty("slow_sb");
   endtask

   task automatic test_pause_resume();
      pulse(1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      speed = 3'd0; slow = 1'b0;
      send_frames(6);
      pulse(1'b0, 1'b1, 1'b0);
      tests_run++;
      if (run_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL pause_running: o_running=%b, required 0", run_m);
      end
      send_frames(10);
      check_time_m("pause_frozen", 0);
      pulse(1'b1, 1'b0, 1'b0);
      send_frames(2);
      check_time_m("resume_time", 1);
      pulse(1'b1, 1'b1, 1'b0);
      tests_run++;
      if (run_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_pause_in_run: o_running=%b, required 0", run_m);
      end
      pulse(1'b1, 1'b1, 1'b0);
      tests_run++;
      if (run_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_pause_in_pause: o_running=%b, required 0", run_m);
      end
      send_frames(1);
      pulse(1'b1, 1'b0, 1'b0);
      send_frames(7);
      check_time_m("resume_acc_kept_7", 1);
      send_frames(1);
      check_time_m("resume_acc_kept_8", 2);
      check_sb_empty("pause_sb");
   endtask

   task automatic test_saturation_stop();
      int ts0;
      do_reset();
      speed = 3'd0; slow = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      ts0 = ticks_s;
      send_frames(40);
      tests_run++;
      if (time_s !== 6'd3 || full_s !== 1'b1 || run_s !== 1'b1) begin
         tests_failed++;
         $display("FAIL sat_state: time=%0d full=%b run=%b, required 3 1 1", time_s, full_s, run_s);
      end
      tests_run++;
      if (ticks_s - ts0 != 3) begin
         tests_failed++;
         $display("FAIL sat_ticks: %0d ticks, required 3", ticks_s - ts0);
      end
      check_time_m("sat_main_time", 5);
      // stop lands on the same edge that would count this frame
      lrck = 1'b1;
      m_frame();
      repeat (2) @(negedge clk);
      pulse(1'b0, 1'b0, 1'b1);
      tests_run++;
      if (time_s !== 6'd0 || full_s !== 1'b0 || run_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL stop_sat: time=%0d full=%b run=%b, required 0 0 0", time_s, full_s, run_s);
      end
      tests_run++;
      if (time_m !== 6'd0 || run_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL stop_main: time=%0d run=%b, required 0 0", time_m, run_m);
      end
      repeat (2) @(negedge clk);
      lrck = 1'b0;
      repeat (4) @(negedge clk);
      tests_run++;
      if (ticks_s - ts0 != 3) begin
         tests_failed++;
         $display("FAIL stop_no_tick: %0d ticks, required 3", ticks_s - ts0);
      end
      check_sb_empty("sat_sb");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1);
   end

   initial begin
      m_reset();
      @(negedge clk);
      test_reset();
      test_normal();
      test_fast3();
      test_slow();
      test_pause_resume();
      test_saturation_stop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/aud_time_counter.md
# aud_time_counter

Elapsed-playback-time counter for the Lab3 audio recorder/player. It sits between the Top control FSM and the two-digit seven-segment time display, and produces the 6-bit seconds value that drives HEX1/HEX0. It counts codec frames from the asynchronous DAC LR clock and scales them by the current play speed (fast ×1..×8, or slow 1/1..1/8), so the display shows elapsed *content* time rather than wall time.

## Interface
Parameters:
- SAMPLE_RATE, 32000: content samples per second; the accumulator wraps at this value.
- MAX_SEC, 63: saturation value of o_time; must be ≤ 63.

Ports:
- i_clk  in  1  system clock (CLK_12M domain)
- i_rst  in  1  reset, synchronous, active-high
- i_lrck  in  1  codec DACLRCK, asynchronous to i_clk; one rising edge = one frame
- i_start  in  1  one-cycle pulse: start or resume
- i_pause  in  1  one-cycle pulse: pause
- i_stop  in  1  one-cycle pulse: stop and clear
- i_speed  in  3  speed code; factor = i_speed+1
- i_is_slow  in  1  1 = slow (divide), 0 = fast (multiply)
- o_time  out  6  elapsed seconds, 0..MAX_SEC
- o_tick  out  1  one-cycle pulse on each o_time increment
- o_running  out  1  state == RUN
- o_full  out  1  o_time == MAX_SEC

## Operation
- i_lrck path: 2-flop synchronizer, then a previous-value register. frame = sync2 & ~prev.
- States:
  - IDLE (reset state). i_start → RUN, clearing the accumulator, the slow divider and o_time.
  - RUN. i_pause → PAUSE. i_stop → IDLE.
  - PAUSE. i_start → RUN, keeping the accumulator, divider and o_time. i_stop → IDLE.
- Event priority when pulses coincide: i_stop > i_pause > i_start.
  - i_start+i_pause in RUN → PAUSE.
  - i_start+i_pause in PAUSE → stays PAUSE.
- i_stop in any state: o_time, accumulator and divider all go to 0 on the next edge.
- Counting is enabled only when the current (registered) state is RUN and o_full = 0. A frame that lands in the same cycle as an i_pause or i_stop pulse is still counted, except that i_stop's clear wins.
- Increment per counted frame:
  - fast (i_is_slow=0): inc = i_speed+1 (1..8).
  - slow (i_is_slow=1): a divider counts frames 0..i_speed. inc = 1 when divider ≥ i_speed, and the divider then returns to 0; otherwise inc = 0 and the divider increments. The `≥` comparison means a lowered i_speed never stalls counting.
  - i_speed and i_is_slow are sampled on every frame; no latching.
- Accumulator: width clog2(SAMPLE_RATE+8).
  - If acc+inc ≥ SAMPLE_RATE: acc ← acc+inc−SAMPLE_RATE, o_time ← o_time+1, o_tick=1.
  - Otherwise acc ← acc+inc.
- Saturation: when o_time reaches MAX_SEC, o_full=1, counting stops and the accumulator freezes. Only i_stop or i_rst clears it.

## Timing
- Reset (i_rst high at a rising edge): o_time=0, o_tick=0, o_running=0, o_full=0, state IDLE, sync flops 0, acc=0, divider=0.
- Latency: an i_lrck rising edge first sampled at clock edge k updates acc/o_time and pulses o_tick at edge k+2. o_tick is high for exactly one cycle.
- i_lrck high/low phases must each be ≥ 2 i_clk periods. At the nominal 32 kHz against 12 MHz this holds trivially.
- o_running and o_full are registered and change on the edge after the causing event.
- Reset asserted mid-run overrides every other input in that cycle.

## Test plan
- Reset: hold i_rst 2 cycles while toggling i_lrck and pulsing i_start → all outputs 0 and state IDLE afterwards.
- Normal speed, SAMPLE_RATE=8: i_start, i_speed=0, i_is_slow=0, 32 frames → o_time=4, exactly 4 o_tick pulses, each 2 cycles after the detected frame edge.
- Fast ×3, SAMPLE_RATE=8: i_speed=2, 8 frames → acc total 24, o_time=3. Then 1 more frame → o_time=3, acc=3.
- Slow ½ then speed change, SAMPLE_RATE=8: i_is_slow=1, i_speed=1, 16 frames → o_time=1. Switch i_speed to 0 with divider=1 → the next frame counts immediately.
- Pause/resume/simultaneous, SAMPLE_RATE=8:
  - 6 frames, i_pause, 10 frames → o_time=0, acc=6.
  - i_start, 2 frames → o_time=1, acc=0.
  - i_start and i_pause on the same cycle in RUN → PAUSE.
- Saturation and stop: MAX_SEC=3, SAMPLE_RATE=8, 40 frames at ×1 → o_time=3, o_full=1, 3 ticks only. i_stop coinciding with a frame → o_time=0, o_full=0, IDLE.
